uctl_tx_pkt_asm: RTL

UCTL_TX_PKT_ASM -- requirements
Module: uctl_tx_pkt_asm

---
 rtl/uctl_pkg.sv | 21 ++
 rtl/uctl_tx_pkt_asm.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/uctl_pkg.sv
// Shared definitions for the UCTL transmit path: packet-assembler FSM encoding
// and the PID byte-form helper.
package uctl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PID,
    ST_FETCH,
    ST_DATA,
    ST_CRC_WAIT,
    ST_CRC0,
    ST_CRC1,
    ST_DONE
  } tx_state_e;

  // On the wire a PID is the nibble followed by its complement.
  function automatic logic [7:0] pid_byte(input logic [3:0] pid);
    return {~pid, pid};
  endfunction

endpackage

// File: rtl/uctl_tx_pkt_asm.sv
// USB data-packet assembler: PID, payload bytes pulled from DMA words LSB-first,
// then the two CRC16 bytes, streamed over the UTMI transmit handshake.
module uctl_tx_pkt_asm #(
  parameter int LEN_W = 11
) (
  input  logic             core_clk,
  input  logic             uctl_rst_n,
  input  logic             sw_rst,
  input  logic             tx_start,
  input  logic [3:0]       tx_pid,
  input  logic [LEN_W-1:0] tx_len,
  input  logic [31:0]      dma_data,
  input  logic             dma_dataValid,
  output logic             dma_dataRd,
  output logic [31:0]      crc_Data,
  output logic [3:0]       crc_DataBE,
  output logic             crc_dataValid,
  output logic             crc_lastData,
  input  logic [15:0]      crc_out,
  output logic [7:0]       utmi_txData,
  output logic             utmi_txValid,
  input  logic             utmi_txReady,
  output logic             tx_busy,
  output logic             tx_done
);
  import uctl_pkg::*;

  tx_state_e        state_q, state_d;
  logic [3:0]       pid_q, pid_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [31:0]      shift_q, shift_d;
  logic [2:0]       bcnt_q, bcnt_d;
  logic [15:0]      hold_q, hold_d;
  logic             pend_q, pend_d;

  always_ff @(posedge core_clk or negedge uctl_rst_n) begin
    if (!uctl_rst_n) begin
      state_q <= ST_IDLE;
      pid_q   <= '0;
      rem_q   <= '0;
      shift_q <= '0;
      bcnt_q  <= '0;
      hold_q  <= '0;
      pend_q  <= 1'b0;
    end else if (sw_rst) begin
      state_q <= ST_IDLE;
      pid_q   <= '0;
      rem_q   <= '0;
      shift_q <= '0;
      bcnt_q  <= '0;
      hold_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pid_q   <= pid_d;
      rem_q   <= rem_d;
      shift_q <= shift_d;
      bcnt_q  <= bcnt_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pid_d         = pid_q;
    rem_d         = rem_q;
    shift_d       = shift_q;
    bcnt_d        = bcnt_q;
    hold_d        = hold_q;
    pend_d        = 1'b0;
    dma_dataRd    = 1'b0;
    crc_Data      = '0;
    crc_DataBE    = '0;
    crc_dataValid = 1'b0;
    crc_lastData  = 1'b0;
    utmi_txData   = '0;
    utmi_txValid  = 1'b0;
    tx_done       = 1'b0;

    // crc_out is valid exactly one cycle after the last word; capture it there,
    // independent of how long the payload bytes take to drain.
    if (pend_q) hold_d = crc_out;

    unique case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          pid_d   = tx_pid;
          rem_d   = tx_len;
          state_d = ST_PID;
        end
      end
      ST_PID: begin
        utmi_txValid = 1'b1;
        utmi_txData  = pid_byte(pid_q);
        if (utmi_txReady) begin
          if (rem_q != '0) begin
            state_d = ST_FETCH;
          end else begin
            hold_d  = 16'h0000;
            state_d = ST_CRC0;
          end
        end
      end
      ST_FETCH: begin
        dma_dataRd = 1'b1;
        if (dma_dataValid) begin
          crc_dataValid = 1'b1;
          crc_Data      = dma_data;
          crc_lastData  = (rem_q <= LEN_W'(4));
          if (rem_q >= LEN_W'(4)) begin
            crc_DataBE = 4'b1111;
            bcnt_d     = 3'd4;
          end else begin
            bcnt_d = rem_q[2:0];
            unique case (rem_q[1:0])
              2'd3:    crc_DataBE = 4'b0111;
              2'd2:    crc_DataBE = 4'b0011;
              default: crc_DataBE = 4'b0001;
            endcase
          end
          shift_d = dma_data;
          pend_d  = crc_lastData;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        utmi_txValid = 1'b1;
        utmi_txData  = shift_q[7:0];
        if (utmi_txReady) begin
          shift_d = {8'h00, shift_q[31:8]};
          rem_d   = rem_q - LEN_W'(1);
          bcnt_d  = bcnt_q - 3'd1;
          if (bcnt_q == 3'd1)
            state_d = (rem_q == LEN_W'(1)) ? ST_CRC_WAIT : ST_FETCH;
        end
      end
      ST_CRC_WAIT: state_d = ST_CRC0;
      ST_CRC0: begin
        utmi_txValid = 1'b1;
        utmi_txData  = hold_q[7:0];
        if (utmi_txReady) state_d = ST_CRC1;
      end
      ST_CRC1: begin
        utmi_txValid = 1'b1;
        utmi_txData  = hold_q[15:8];
        if (utmi_txReady) state_d = ST_DONE;
      end
      ST_DONE: begin
        tx_done = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tx_busy = (state_q != ST_IDLE);

endmodule
